// File: rtl/centroid_overlay_pkg.sv
// Shared types, widths and helpers for the centroid overlay video stage.
// Coordinates coming from the centroid block are 32 bits wide; on-screen
// positions are 11 bits, so out-of-range coordinates saturate to 2047.
package centroid_pkg;

  localparam int POS_W   = 11;
  localparam int COORD_W = 32;
  localparam int RGB_W   = 24;

  localparam logic [RGB_W-1:0] MARK_RGB_DEF = 24'hFF0000;
  localparam logic [RGB_W-1:0] RGB_BLACK    = 24'h000000;
  localparam logic [RGB_W-1:0] RGB_WHITE    = 24'hFFFFFF;

  typedef logic [POS_W-1:0]        pos_t;
  typedef logic signed [POS_W:0]   delta_t;

  localparam pos_t POS_MAX = 11'd2047;

  // Clamp a 32-bit coordinate into the 11-bit on-screen range.
  function automatic pos_t sat11(input logic [COORD_W-1:0] v);
    if (v > COORD_W'(POS_MAX)) begin
      sat11 = POS_MAX;
    end else begin
      sat11 = v[POS_W-1:0];
    end
  endfunction

  // Magnitude of a 12-bit signed delta; range is +/-2047 so it never overflows.
  function automatic delta_t abs12(input delta_t d);
    if (d[POS_W]) begin
      abs12 = -d;
    end else begin
      abs12 = d;
    end
  endfunction

endpackage

// File: rtl/centroid_overlay_pix_pos_cnt.sv
// Pixel position counter for a de/h_sync/v_sync stream.
// xp/yp give the position of the pixel currently on the input (value before
// its increment). The line flag records that the current line carried active
// pixels, so only lines with data advance the row on the next h_sync.
module pix_pos_cnt
  import centroid_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             de_i,
  input  logic             h_sync_i,
  input  logic             v_sync_i,
  output logic [POS_W-1:0] xp_o,
  output logic [POS_W-1:0] yp_o
);

  pos_t xp_q, xp_d;
  pos_t yp_q, yp_d;
  logic line_q, line_d;

  // Next-state counting; de beats h_sync for xp, v_sync beats everything.
  always_comb begin
    xp_d   = xp_q;
    yp_d   = yp_q;
    line_d = line_q;

    if (v_sync_i) begin
      xp_d = 11'd0;
    end else if (de_i) begin
      xp_d = xp_q + 11'd1;
    end else if (h_sync_i) begin
      xp_d = 11'd0;
    end else begin
      xp_d = xp_q;
    end

    if (v_sync_i) begin
      yp_d = 11'd0;
    end else if (h_sync_i && line_q) begin
      yp_d = yp_q + 11'd1;
    end else begin
      yp_d = yp_q;
    end

    if (de_i) begin
      line_d = 1'b1;
    end else if (h_sync_i) begin
      line_d = 1'b0;
    end else begin
      line_d = line_q;
    end
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      xp_q   <= 11'd0;
      yp_q   <= 11'd0;
      line_q <= 1'b0;
    end else begin
      xp_q   <= xp_d;
      yp_q   <= yp_d;
      line_q <= line_d;
    end
  end

  assign xp_o = xp_q;
  assign yp_o = yp_q;

endmodule

// File: rtl/centroid_overlay.sv
// Centroid crosshair overlay: draws a MARK_RGB crosshair at the centroid
// latched at the end of vertical blanking, on a stream delayed by 2 clocks.
// Optional build macro CENTROID_OVERLAY_BOX_EN adds a square outline of
// half-size BOX_HALF around the centroid.
module centroid_overlay
  import centroid_pkg::*;
#(
  parameter int               ARM      = 10,
  parameter logic [RGB_W-1:0] MARK_RGB = MARK_RGB_DEF,
  parameter int               BOX_HALF = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [RGB_W-1:0]   pixel_in,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               marker_en,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [RGB_W-1:0]   pixel_out
);

  // Sizes must fit the 12-bit signed delta compare.
  if (ARM < 0 || ARM > 2047 || BOX_HALF < 0 || BOX_HALF > 2047) begin : g_cfg_bad
    $error("centroid_overlay: ARM/BOX_HALF out of range");
  end

  localparam delta_t ARM_D = delta_t'(ARM);

  pos_t xp_s, yp_s;

  pix_pos_cnt u_pos (
    .clk      (clk),
    .rst      (rst),
    .de_i     (de_in),
    .h_sync_i (h_sync_in),
    .v_sync_i (v_sync_in),
    .xp_o     (xp_s),
    .yp_o     (yp_s)
  );

  logic vs_prev_q;
  pos_t cx_q, cy_q;
  logic en_q;

  // Latch centroid and enable on v_sync falling edge; hold for the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      cx_q      <= 11'd0;
      cy_q      <= 11'd0;
      en_q      <= 1'b0;
    end else begin
      vs_prev_q <= v_sync_in;
      if (vs_prev_q && !v_sync_in) begin
        cx_q <= sat11(x_in);
        cy_q <= sat11(y_in);
        en_q <= marker_en;
      end else begin
        cx_q <= cx_q;
        cy_q <= cy_q;
        en_q <= en_q;
      end
    end
  end

  delta_t dx_s, dy_s, adx_s, ady_s;
  logic   cross_s, box_s, hit_s;

  // Signed distance from the centroid; zero-extend so no unsigned wrap.
  always_comb begin
    dx_s  = $signed({1'b0, xp_s}) - $signed({1'b0, cx_q});
    dy_s  = $signed({1'b0, yp_s}) - $signed({1'b0, cy_q});
    adx_s = abs12(dx_s);
    ady_s = abs12(dy_s);
  end

  // Marker membership for the pixel currently on the input.
  always_comb begin
    cross_s = ((dx_s == 12'sd0) && (ady_s <= ARM_D)) ||
              ((dy_s == 12'sd0) && (adx_s <= ARM_D));
`ifdef CENTROID_OVERLAY_BOX_EN
    box_s   = ((adx_s == delta_t'(BOX_HALF)) && (ady_s <= delta_t'(BOX_HALF))) ||
              ((ady_s == delta_t'(BOX_HALF)) && (adx_s <= delta_t'(BOX_HALF)));
`else
    box_s   = 1'b0;
`endif
    hit_s   = en_q && de_in && (cross_s || box_s);
  end

  logic             de_q, hs_q, vs_q, hit_q;
  logic [RGB_W-1:0] pix_q;

  // Stage 1: register the stream alongside the hit decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      hit_q <= 1'b0;
      pix_q <= RGB_BLACK;
    end else begin
      de_q  <= de_in;
      hs_q  <= h_sync_in;
      vs_q  <= v_sync_in;
      hit_q <= hit_s;
      pix_q <= pixel_in;
    end
  end

  // Stage 2: registered outputs, marker colour substituted on hit pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= RGB_BLACK;
    end else begin
      de_out     <= de_q;
      h_sync_out <= hs_q;
      v_sync_out <= vs_q;
      pixel_out  <= hit_q ? MARK_RGB : pix_q;
    end
  end

endmodule

// File: tb/tb_centroid_overlay.sv
// Directed bench for centroid_overlay: 64x48 frames, per-cycle stream check
// against a 2-deep expectation pipeline, plus per-frame marker pixel counts.
module tb_centroid_overlay;

  localparam int          ARM  = 10;
  localparam logic [23:0] MARK = 24'hFF0000;
  localparam int          BOXH = 5;
  localparam int          W    = 64;
  localparam int          H    = 48;

  logic        clk = 1'b0;
  logic        rst, de_in, h_sync_in, v_sync_in, marker_en;
  logic [23:0] pixel_in;
  logic [31:0] x_in, y_in;
  logic        de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_out;

  always #5 clk = ~clk;

  centroid_overlay #(.ARM(ARM), .MARK_RGB(MARK), .BOX_HALF(BOXH)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .pixel_in(pixel_in), .x_in(x_in), .y_in(y_in),
    .marker_en(marker_en), .de_out(de_out), .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out), .pixel_out(pixel_out)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        en;
    logic [31:0] x2;
    logic        en2;
    int          chg_row;
    int          exp_marks;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   obs_marks = 0;
  exp_t e1, e2;
  int   bcx = 0, bcy = 0;
  logic ben = 1'b0;
  vec_t tbl[7];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat(input logic [31:0] v);
    return (v > 32'd2047) ? 2047 : int'(v);
  endfunction

  function automatic logic model_mark(input int r, input int c);
    int   dx, dy;
    logic m;
    dx = c - bcx;
    dy = r - bcy;
    m  = ((dx == 0) && (iabs(dy) <= ARM)) || ((dy == 0) && (iabs(dx) <= ARM));
`ifdef CENTROID_OVERLAY_BOX_EN
    m  = m || ((iabs(dx) == BOXH) && (iabs(dy) <= BOXH)) ||
              ((iabs(dy) == BOXH) && (iabs(dx) <= BOXH));
`endif
    return ben && m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, want);
    end
  endtask

  // Drive one clock of input, then check the output against input from 2 clocks ago.
  task automatic cycle(input logic rv, input logic dv, input logic hv, input logic vv,
                       input logic [23:0] pv, input logic mv);
    exp_t cur;
    rst       = rv;
    de_in     = dv;
    h_sync_in = hv;
    v_sync_in = vv;
    pixel_in  = pv;
    cur.de  = dv;
    cur.hs  = hv;
    cur.vs  = vv;
    cur.pix = mv ? MARK : pv;
    @(posedge clk);
    #1;
    if (rv) begin
      e1 = '0;
      e2 = '0;
    end else begin
      e2 = e1;
      e1 = cur;
    end
    chk("stream", {5'd0, de_out, h_sync_out, v_sync_out, pixel_out}, {5'd0, e2});
    if (de_out && pixel_out == MARK) obs_marks++;
  endtask

  task automatic run_frame(input logic [31:0] x, input logic [31:0] y, input logic en,
                           input logic [31:0] x2, input logic en2, input int chg_row);
    x_in      = x;
    y_in      = y;
    marker_en = en;
    obs_marks = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0);
    bcx = sat(x);
    bcy = sat(y);
    ben = en;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0);
    for (int r = 0; r < H; r++) begin
      if (r == chg_row) begin
        x_in      = x2;
        marker_en = en2;
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h00A5A5, 1'b0);
      for (int c = 0; c < W; c++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, model_mark(r, c));
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 24'h5A5A00, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h0F0F0F, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h0F0F0F, 1'b0);
  endtask

  initial begin
`ifdef CENTROID_OVERLAY_BOX_EN
    tbl[0] = '{32'd20, 32'd10, 1'b1, 32'd20, 1'b1, -1, 77};
    tbl[1] = '{32'd2,  32'd2,  1'b1, 32'd2,  1'b1, -1, 38};
    tbl[2] = '{32'd20, 32'd10, 1'b1, 32'd40, 1'b0, 24, 77};
    tbl[3] = '{32'd40, 32'd10, 1'b1, 32'd40, 1'b1, -1, 77};
    tbl[4] = '{32'd20, 32'd10, 1'b0, 32'd20, 1'b1, 24, 0};
    tbl[5] = '{32'h0001_0000, 32'd10, 1'b1, 32'h0001_0000, 1'b1, -1, 0};
    tbl[6] = '{32'd63, 32'd47, 1'b1, 32'd63, 1'b1, -1, 30};
`else
    tbl[0] = '{32'd20, 32'd10, 1'b1, 32'd20, 1'b1, -1, 41};
    tbl[1] = '{32'd2,  32'd2,  1'b1, 32'd2,  1'b1, -1, 25};
    tbl[2] = '{32'd20, 32'd10, 1'b1, 32'd40, 1'b0, 24, 41};
    tbl[3] = '{32'd40, 32'd10, 1'b1, 32'd40, 1'b1, -1, 41};
    tbl[4] = '{32'd20, 32'd10, 1'b0, 32'd20, 1'b1, 24, 0};
    tbl[5] = '{32'h0001_0000, 32'd10, 1'b1, 32'h0001_0000, 1'b1, -1, 0};
    tbl[6] = '{32'd63, 32'd47, 1'b1, 32'd63, 1'b1, -1, 21};
`endif
    e1 = '0;
    e2 = '0;
    x_in = 32'd0;
    y_in = 32'd0;
    marker_en = 1'b0;

    // Power-up reset, then reset held for 3 cycles in the middle of an active line.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'h0000AA + 24'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b0);
      chk("rst_out", {5'd0, de_out, h_sync_out, v_sync_out, pixel_out}, 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'h010203, 1'b0);
    chk("rst_lat1_de", {31'd0, de_out}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'h040506, 1'b0);
    chk("rst_lat2_de", {31'd0, de_out}, 32'd1);
    chk("rst_lat2_pix", {8'd0, pixel_out}, 32'h00010203);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0);

    // Frame scenarios: marker pixel count per frame plus the per-cycle stream check.
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].x, tbl[i].y, tbl[i].en, tbl[i].x2, tbl[i].en2, tbl[i].chg_row);
      chk($sformatf("marks%0d", i), 32'(obs_marks), 32'(tbl[i].exp_marks));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/centroid_overlay.md
Name: centroid_overlay

Overview:
- Downstream video stage of the centroid block.
- Takes the pixel stream (de/h_sync/v_sync/RGB) plus the centroid coordinates x, y and draws a crosshair marker of fixed colour at (x, y) on the outgoing stream.
- Coordinates are latched once per frame, so the marker is stable for a whole frame.
- Output stream is the input stream delayed by exactly 2 clocks, with marker pixels substituted.

Parameters:
- ARM, 10: crosshair arm length in pixels, each side of centre.
- MARK_RGB, 24'hFF0000: marker colour.
- BOX_HALF, 16: half-size of the bounding square; used only with the optional feature.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- de_in  in  1  data enable
- h_sync_in  in  1  horizontal sync, active high
- v_sync_in  in  1  vertical sync, active high
- pixel_in  in  24  RGB888 pixel
- x_in  in  32  centroid column, from the centroid block
- y_in  in  32  centroid row, from the centroid block
- marker_en  in  1  draw enable; sampled at the frame latch point
- de_out  out  1  de_in delayed by 2 clocks
- h_sync_out  out  1  h_sync_in delayed by 2 clocks
- v_sync_out  out  1  v_sync_in delayed by 2 clocks
- pixel_out  out  24  pixel_in delayed by 2 clocks, or MARK_RGB on marker pixels

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; position counters 0; latched cx, cy 0; latched enable 0; the line flag in the position counter is cleared. Reset wins over every other event in that cycle.
- Position counting (stage 0):
  - v_sync_in=1: xp <= 0 and yp <= 0.
  - h_sync_in=1: xp <= 0; if the line flag is set, yp <= yp+1 and the flag is cleared.
  - de_in=1: xp <= xp+1 and the flag is set. If de_in and h_sync_in are both 1 in the same cycle, de_in wins for xp.
  - An active pixel's position is the counter value before its increment: first pixel of a frame is (0,0).
  - xp and yp are 11 bits; they wrap at 2047 with no error.
- Frame latch:
  - Edge detect on v_sync_in using a registered previous value.
  - On the falling edge (end of vertical blanking): cx <= sat11(x_in), cy <= sat11(y_in), en_q <= marker_en.
  - sat11(v) is 2047 if v > 2047, otherwise v[10:0].
  - Between latches, changes on x_in, y_in and marker_en have no effect.
- Hit test (stage 1, registered):
  - Compute dx = xp - cx and dy = yp - cy as 12-bit signed values; no unsigned wrap.
  - hit = en_q & de_in & ((dx==0 & |dy|<=ARM) | (dy==0 & |dx|<=ARM)).
  - Arms clip naturally at the frame edges; no wrap to the opposite edge.
- Output (stage 2, registered):
  - pixel_out = hit_d ? MARK_RGB : pixel_d.
  - Syncs and de are delayed through the same two stages, so alignment is exact.
  - When de_out=0, pixel_out passes the delayed input unchanged.
- Latency: fixed 2 clocks for all outputs; no backpressure and no handshake.

Optional Feature:
- Macro: CENTROID_OVERLAY_BOX_EN.
- Defined: additionally draw a 1-pixel square outline. A pixel is on the outline when (|dx|==BOX_HALF & |dy|<=BOX_HALF) | (|dy|==BOX_HALF & |dx|<=BOX_HALF). It is gated by en_q and drawn in MARK_RGB. The crosshair is still drawn.
- Undefined: crosshair only; BOX_HALF is unused and no box logic is built.

Decomposition:
- Package centroid_pkg:
  - POS_W=11 and COORD_W=32.
  - RGB_W=24.
  - Default colour constants.
  - The sat11 function.
- One natural sub-module: pix_pos_cnt. It holds the xp/yp counters and line flag. It is reused later by other stream stages and must match the counting rules above exactly.

Test Plan:
- Reset: hold rst for 3 cycles during an active line -> all outputs 0. After release, the first output pixel appears 2 clocks after its input.
- 64x48 frame, x_in=20, y_in=10, marker_en=1 set before the v_sync falling edge; ARM=10, white input -> MARK_RGB on row 10, cols 10..30, and on col 20, rows 0..20. All other pixels are white. Syncs match the input delayed by 2 clocks.
- x_in=2, y_in=2 -> arms clipped: row 2 cols 0..12 and col 2 rows 0..12 marked. No marks appear at cols 54..63 or rows 38..47.
- Change x_in 20->40 in mid-frame -> marker stays at col 20 for the rest of the frame and moves to col 40 from the next frame.
- marker_en=0 at latch, or x_in=32'h0001_0000 (saturated to 2047) -> output equals input delayed by 2 clocks for the whole frame.
- With CENTROID_OVERLAY_BOX_EN and BOX_HALF=5 at (20,10) -> outline on rows 5 and 15 (cols 15..25) and on cols 15 and 25 (rows 5..15), plus the crosshair.
